rf_safe_shutdown: RTL and testbench
===================================

Name: rf_safe_shutdown

Overview:
- Sits directly downstream of the watchdog timer and consumes its `force_reset` pulse.
- On a fault, ramps the AM carrier amplitude to zero without a hard step, holds mute, then stays in a safe state until the host re-arms.
- Placed between the modulator amplitude path and the DAC interface, so every sample to the DAC passes through it.

Parameters:
- AW, 12, amplitude sample width (unsigned).
- RAMP_DIV, 4, clock cycles between gain decrements during the ramp (≥1).
- STEP, 32, gain decrement per ramp tick (1..256).
- HOLD_CYCLES, 16, mute-hold duration after the gain reaches 0 (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- force_reset  in  1  fault pulse from the watchdog; level-sampled every cycle
- rearm  in  1  host re-arm request; one-cycle pulse
- amp_in  in  AW  amplitude sample from the modulator
- amp_out  out  AW  scaled amplitude to the DAC
- mute  out  1  high when the output is forced to 0 (HOLD/SAFE)
- busy  out  1  high in RAMP or HOLD
- state  out  2  encoded FSM state for status register
- gain  out  9  current gain, 0..256

Behaviour:
- Reset (async, rst=1):
  - state=SAFE, gain=0.
  - amp_out=0, mute=1, busy=0.
  - All counters are 0.
  - The output is safe until a rearm.
- Encoding: RUN=0, RAMP=1, HOLD=2, SAFE=3.
- Datapath:
  - amp_out is registered, 1-cycle latency.
  - amp_out = (amp_in * gain) >> 8, computed at AW+9 bits and truncated to AW.
  - gain=256 gives an exact passthrough; gain=0 gives 0.
  - In HOLD/SAFE, amp_out = 0 regardless of gain.
- RUN:
  - gain=256, mute=0.
  - force_reset=1 → RAMP next cycle; the ramp divider is cleared.
- RAMP:
  - The divider counts 0..RAMP_DIV-1. On wrap, gain ← max(gain-STEP, 0).
  - When the registered gain is 0 → HOLD next cycle; the hold counter is cleared.
  - force_reset and rearm are ignored in RAMP.
- HOLD:
  - mute=1. The hold counter increments.
  - After HOLD_CYCLES cycles in HOLD → SAFE.
  - force_reset=1 in HOLD restarts the hold counter at 0.
  - rearm is ignored.
- SAFE:
  - mute=1.
  - rearm=1 with force_reset=0 → RUN next cycle; gain=256, so amp_out follows amp_in one cycle later.
  - rearm and force_reset together: force_reset wins and the block stays SAFE.
- Ramp length: ceil(256/STEP)*RAMP_DIV cycles. With defaults, 8 ticks = 32 cycles. A non-dividing STEP saturates at 0 on the last tick.
- Reset mid-ramp or mid-hold: immediate SAFE, gain=0, amp_out=0 asynchronously.
- busy = (state==RAMP) || (state==HOLD).

Optional Feature:
- Macro: RF_SHUTDOWN_EVENT_COUNT_EN.
- With the macro defined:
  - Extra output `shutdown_count` [15:0], a saturating counter (stops at 16'hFFFF).
  - Increments on each RUN→RAMP transition.
  - Cleared only by rst.
- Without the macro: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package `rf_safety_pkg`:
  - state enum `shutdown_state_t` (RUN/RAMP/HOLD/SAFE) with fixed 2-bit encoding.
  - `GAIN_W=9`, `GAIN_UNITY=9'd256`.
  - default localparams for RAMP_DIV/STEP/HOLD_CYCLES.
- One natural sub-module, `rf_gain_scaler`:
  - registered multiply/shift, with a mute override input.
  - FSM, divider and hold counter stay in the top block.

Test Plan (defaults AW=12, RAMP_DIV=4, STEP=32, HOLD_CYCLES=16):
- Reset then rearm pulse, amp_in=12'hABC → state=RUN, mute=0, amp_out=12'hABC one cycle after gain=256.
- RUN, amp_in=12'hFFF, force_reset pulse → gain steps 256,224,…,0 every 4 cycles. amp_out at gain=128 is 12'h7FF. HOLD is entered 32 cycles after RAMP entry.
- HOLD entered; force_reset pulse on hold cycle 10 → the hold counter restarts. SAFE is reached 16 cycles after the pulse, not 6.
- SAFE with rearm=1 and force_reset=1 in the same cycle → stays SAFE, mute=1, amp_out=0.
- rst asserted mid-RAMP at gain=160 → same cycle: amp_out=0, mute=1, gain=0, state=SAFE. A rearm pulse in RAMP, before the rst, is ignored.
- With RF_SHUTDOWN_EVENT_COUNT_EN: three full fault/rearm cycles → shutdown_count=3. rst → 0.

Source files
------------

// File: rtl/rf_safety_pkg.sv
// Shared types and defaults for the RF safe-shutdown path.
// States, gain format and default timing parameters.
package rf_safety_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_SAFE = 2'd3
  } shutdown_state_t;

  localparam int GAIN_W = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  localparam int DEF_AW          = 12;
  localparam int DEF_RAMP_DIV    = 4;
  localparam int DEF_STEP        = 32;
  localparam int DEF_HOLD_CYCLES = 16;

  function automatic logic is_muted(
    input shutdown_state_t s
  );
    return (s == ST_HOLD) || (s == ST_SAFE);
  endfunction

endpackage

// File: rtl/rf_gain_scaler.sv
// Registered amplitude scaler: (amp * gain) >> 8 with a mute override.
// Gain is Q1.8, so 256 is unity.
module rf_gain_scaler
  import rf_safety_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     amp_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic              mute_i,
  output logic [AW-1:0]     amp_o
);

  logic [AW+8:0] prod;
  logic [AW-1:0] amp_d;
  logic [AW-1:0] amp_q;

  assign prod = (AW+9)'(amp_i) * (AW+9)'(gain_i);

  always_comb begin
    amp_d = AW'(prod >> 8);
    if (mute_i) begin
      amp_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amp_q <= '0;
    end else begin
      amp_q <= amp_d;
    end
  end

  assign amp_o = amp_q;

endmodule

// File: rtl/rf_safe_shutdown.sv
// Fault-driven carrier ramp-down, mute hold and safe latch before the DAC.
// Optional RF_SHUTDOWN_EVENT_COUNT_EN adds a saturating shutdown counter.
module rf_safe_shutdown
  import rf_safety_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int RAMP_DIV    = DEF_RAMP_DIV,
  parameter int STEP        = DEF_STEP,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              force_reset,
  input  logic              rearm,
  input  logic [AW-1:0]     amp_in,
  output logic [AW-1:0]     amp_out,
  output logic              mute,
  output logic              busy,
  output logic [1:0]        state,
  output logic [GAIN_W-1:0] gain
`ifdef RF_SHUTDOWN_EVENT_COUNT_EN
  ,
  output logic [15:0]       shutdown_count
`endif
);

  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);

  shutdown_state_t   state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [GAIN_W-1:0] gain_dec;

  // Saturating decrement so a non-dividing STEP still lands on 0.
  assign gain_dec = (gain_q > STEP_G) ? gain_q - STEP_G : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SAFE;
      gain_q  <= '0;
      div_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    div_d   = div_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RUN: begin
        gain_d = GAIN_UNITY;
        if (force_reset) begin
          state_d = ST_RAMP;
          div_d   = '0;
        end
      end
      ST_RAMP: begin
        if (gain_q == '0) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          gain_d = gain_dec;
          if (gain_dec == '0) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_HOLD: begin
        if (force_reset) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_SAFE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_SAFE: begin
        if (rearm && !force_reset) begin
          state_d = ST_RUN;
          gain_d  = GAIN_UNITY;
        end
      end
      default: begin
        state_d = ST_SAFE;
        gain_d  = '0;
      end
    endcase
  end

  assign mute  = is_muted(state_q);
  assign busy  = (state_q == ST_RAMP) || (state_q == ST_HOLD);
  assign state = state_q;
  assign gain  = gain_q;

  rf_gain_scaler #(
    .AW(AW)
  ) u_scaler (
    .clk   (clk),
    .rst   (rst),
    .amp_i (amp_in),
    .gain_i(gain_q),
    .mute_i(mute),
    .amp_o (amp_out)
  );

`ifdef RF_SHUTDOWN_EVENT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_RUN && force_reset && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shutdown_count = cnt_q;
`endif

endmodule

// File: tb/tb_rf_safe_shutdown.sv
// Randomized bench for rf_safe_shutdown against a phase/elapsed-time model.
// Directed scenarios cover rearm, ramp timing, hold restart and async reset.
module tb_rf_safe_shutdown;

  localparam int AW = 12;
  localparam int RAMP_DIV = 4;
  localparam int STEP = 32;
  localparam int HOLD_CYCLES = 16;
  localparam int RAMP_LEN = ((256 + STEP - 1) / STEP) * RAMP_DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          force_reset;
  logic          rearm;
  logic [AW-1:0] amp_in;
  logic [AW-1:0] amp_out;
  logic          mute;
  logic          busy;
  logic [1:0]    state;
  logic [8:0]    gain;
`ifdef RF_SHUTDOWN_EVENT_COUNT_EN
  logic [15:0]   shutdown_count;
`endif

  rf_safe_shutdown #(
    .AW(AW),
    .RAMP_DIV(RAMP_DIV),
    .STEP(STEP),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .force_reset(force_reset),
    .rearm      (rearm),
    .amp_in     (amp_in),
    .amp_out    (amp_out),
    .mute       (mute),
    .busy       (busy),
    .state      (state),
    .gain       (gain)
`ifdef RF_SHUTDOWN_EVENT_COUNT_EN
    ,
    .shutdown_count(shutdown_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: phase 0=RUN 1=RAMP 2=HOLD 3=SAFE, t = cycles since phase (re)start.
  int m_st, m_t, m_amp, m_cnt;

  function automatic int g_of(input int st, input int t);
    int g;
    case (st)
      0: g = 256;
      1: begin
        g = 256 - STEP * (t / RAMP_DIV);
        if (g < 0) g = 0;
      end
      default: g = 0;
    endcase
    return g;
  endfunction

  task automatic m_reset();
    m_st = 3; m_t = 0; m_amp = 0; m_cnt = 0;
  endtask

  task automatic m_step(input logic fr, input logic ra, input int ain);
    int g;
    g = g_of(m_st, m_t);
    m_amp = (m_st >= 2) ? 0 : ((ain * g) >> 8) & 12'hFFF;
    case (m_st)
      0: if (fr) begin
        m_st = 1; m_t = 0;
        if (m_cnt < 65535) m_cnt++;
      end
      1: begin
        m_t++;
        if (m_t == RAMP_LEN) begin m_st = 2; m_t = 0; end
      end
      2: begin
        if (fr) m_t = 0;
        else begin
          m_t++;
          if (m_t == HOLD_CYCLES) begin m_st = 3; m_t = 0; end
        end
      end
      default: if (ra && !fr) begin m_st = 0; m_t = 0; end
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_st));
    chk("gain", 32'(gain), 32'(g_of(m_st, m_t)));
    chk("amp_out", 32'(amp_out), 32'(m_amp));
    chk("mute", 32'(mute), 32'(m_st >= 2));
    chk("busy", 32'(busy), 32'(m_st == 1 || m_st == 2));
`ifdef RF_SHUTDOWN_EVENT_COUNT_EN
    chk("count", 32'(shutdown_count), 32'(m_cnt));
`endif
  endtask

  task automatic cyc(input logic fr, input logic ra, input logic [AW-1:0] ain);
    force_reset = fr;
    rearm = ra;
    amp_in = ain;
    @(posedge clk);
    m_step(fr, ra, int'(ain));
    #1;
    check_all();
  endtask

  task automatic arst();
    #2 rst = 1'b1;
    m_reset();
    #1;
    check_all();
    chk("rst_amp", 32'(amp_out), 32'h0);
    chk("rst_state", 32'(state), 32'd3);
    #2 rst = 1'b0;
  endtask

  int n;
  bit seen128;
  bit done128;

  initial begin
    rst = 1'b1;
    force_reset = 1'b0;
    rearm = 1'b0;
    amp_in = '0;
    m_reset();
    #12;
    check_all();
    chk("rst_gain", 32'(gain), 32'h0);
    rst = 1'b0;

    // Rearm from SAFE, passthrough at unity gain.
    cyc(0, 1, 12'hABC);
    chk("run_state", 32'(state), 32'd0);
    chk("run_mute", 32'(mute), 32'd0);
    cyc(0, 0, 12'hABC);
    chk("passthru", 32'(amp_out), 32'hABC);

    // Ramp with full-scale input; HOLD must follow RAMP entry by RAMP_LEN.
    cyc(1, 0, 12'hFFF);
    n = 0; seen128 = 0; done128 = 0;
    while (state != 2'd2 && n < 100) begin
      seen128 = (g_of(m_st, m_t) == 128);
      cyc(0, 0, 12'hFFF);
      n++;
      if (seen128 && !done128) begin
        chk("amp@128", 32'(amp_out), 32'h7FF);
        done128 = 1;
      end
    end
    chk("ramp_len", 32'(n), 32'(RAMP_LEN));
    chk("seen128", 32'(done128), 32'd1);

    // Fault on hold cycle 10 restarts the hold period.
    for (int i = 0; i < 10; i++) cyc(0, 1, 12'h123);
    cyc(1, 0, 12'h123);
    n = 0;
    while (state != 2'd3 && n < 40) begin
      cyc(0, 0, 12'h123);
      n++;
    end
    chk("hold_restart", 32'(n), 32'(HOLD_CYCLES));

    // Rearm together with a fault keeps the block safe.
    cyc(1, 1, 12'hFFF);
    chk("both_state", 32'(state), 32'd3);
    chk("both_mute", 32'(mute), 32'd1);
    chk("both_amp", 32'(amp_out), 32'd0);

    // Async reset mid-ramp at gain 160; a rearm inside RAMP is ignored.
    cyc(0, 1, 12'h800);
    cyc(1, 0, 12'h800);
    cyc(0, 1, 12'h800);
    n = 0;
    while (gain != 9'd160 && n < 40) begin
      cyc(0, 0, 12'h800);
      n++;
    end
    chk("ramp_rearm", 32'(state), 32'd1);
    chk("gain160", 32'(gain), 32'd160);
    arst();
    chk("rst_mute", 32'(mute), 32'd1);
    chk("rst_gain2", 32'(gain), 32'd0);

    // Three complete fault/rearm loops.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 12'h456);
      cyc(1, 0, 12'h456);
      n = 0;
      while (state != 2'd3 && n < 200) begin
        cyc(0, 0, 12'(n));
        n++;
      end
    end
    chk("loops_safe", 32'(state), 32'd3);
`ifdef RF_SHUTDOWN_EVENT_COUNT_EN
    chk("count3", 32'(shutdown_count), 32'd3);
    arst();
    chk("count_rst", 32'(shutdown_count), 32'd0);
`endif

    // Random traffic with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 12) == 0, ($urandom % 5) == 0,
          12'($urandom));
      if (($urandom % 700) == 0) arst();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
